// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : store_buffer
//  Purpose  : Circular FIFO of pending CPU stores. Drains one entry per cycle
//             to data memory when the port is free, and checks buffered
//             entries against a concurrent load address.
//  Options  : STORE_BUF_FWD_EN - when defined, ld_data forwards the youngest
//             matching entry; otherwise ld_hit is a stall request only and
//             ld_data is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module store_buffer #(
  parameter int unsigned DEPTH = 4  // power of two, 2..16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [31:0] st_pc,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic [31:0] ld_data,
  input  logic        dm_busy,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [31:0] dm_pc,
  output logic [4:0]  count
);

  localparam int unsigned c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  c_full  = 5'(DEPTH);

  logic [c_ptr_w-1:0] head_q, head_d;
  logic [c_ptr_w-1:0] tail_q, tail_d;
  logic [4:0]         count_q, count_d;

  logic [31:0] addr_q [DEPTH];
  logic [31:0] addr_d [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [31:0] data_d [DEPTH];
  logic [31:0] pc_q   [DEPTH];
  logic [31:0] pc_d   [DEPTH];

  logic w_push;
  logic w_pop;
  logic w_nonempty;
  logic w_match_any;
`ifdef STORE_BUF_FWD_EN
  logic [31:0] w_fwd_data;
`endif

  // Handshake decode: a full buffer refuses stores; the head drains whenever
  // the memory port is free. An entry pushed this cycle is not yet counted,
  // so it cannot drain in its own push cycle.
  always_comb begin
    w_nonempty = (count_q != 5'd0);
    st_ready   = (count_q != c_full);
    dm_we      = w_nonempty && !dm_busy;
    w_push     = st_valid && st_ready;
    w_pop      = dm_we;
    dm_addr    = w_nonempty ? addr_q[head_q] : 32'd0;
    dm_wdata   = w_nonempty ? data_q[head_q] : 32'd0;
    dm_pc      = w_nonempty ? pc_q[head_q]   : 32'd0;
    count      = count_q;
  end

  // Next-state for pointers and occupancy; pointers wrap by natural overflow.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (w_push) begin
      tail_d = tail_q + c_ptr_w'(1);
    end
    if (w_pop) begin
      head_d = head_q + c_ptr_w'(1);
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  // Entry storage next-state: only the tail slot is written on a push.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    pc_d   = pc_q;
    if (w_push) begin
      addr_d[tail_q] = st_addr;
      data_d[tail_q] = st_data;
      pc_d[tail_q]   = st_pc;
    end
  end

  // Load match: scan valid entries from oldest to youngest so the last hit
  // is the youngest. The head entry still counts while it is being popped.
  always_comb begin
    w_match_any = 1'b0;
`ifdef STORE_BUF_FWD_EN
    w_fwd_data  = 32'd0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if ((5'(i) < count_q) && (addr_q[head_q + c_ptr_w'(i)] == ld_addr)) begin
        w_match_any = 1'b1;
`ifdef STORE_BUF_FWD_EN
        w_fwd_data  = data_q[head_q + c_ptr_w'(i)];
`endif
      end
    end
    ld_hit = ld_valid && w_match_any;
`ifdef STORE_BUF_FWD_EN
    ld_data = ld_hit ? w_fwd_data : 32'd0;
`else
    ld_data = 32'd0;
`endif
  end

  // Control state: reset clears occupancy at once, discarding pending stores.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 5'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset: slots are only visible once counted valid.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    pc_q   <= pc_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_buffer
//  Purpose  : Directed bench for store_buffer with a queue-based reference
//             model compared on every falling edge, plus literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [31:0] st_pc;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        dm_busy;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_pc;
  logic [4:0]  count;

  int n_vec;
  int n_fail;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_pc    (st_pc),
    .st_ready (st_ready),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_hit   (ld_hit),
    .ld_data  (ld_data),
    .dm_busy  (dm_busy),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_pc    (dm_pc),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] p;
  } ent_t;

  ent_t mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: a plain FIFO of pending stores.
  always @(posedge clk or posedge reset) begin
    bit do_push;
    bit do_pop;
    ent_t e;
    if (reset) begin
      mq.delete();
    end else begin
      do_push = st_valid && (mq.size() != DEPTH);
      do_pop  = (mq.size() != 0) && !dm_busy;
      e.a = st_addr;
      e.d = st_data;
      e.p = st_pc;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
  end

  // Every falling edge: outputs must match what the model's contents imply.
  always @(negedge clk) begin
    logic        e_hit;
    logic [31:0] e_ld;
    int          sz;
    sz    = mq.size();
    e_hit = 1'b0;
    e_ld  = 32'd0;
    foreach (mq[k]) begin
      if (mq[k].a == ld_addr) begin
        e_hit = 1'b1;
        e_ld  = mq[k].d;
      end
    end
    e_hit = e_hit && ld_valid;
    if (!e_hit) e_ld = 32'd0;
`ifndef STORE_BUF_FWD_EN
    e_ld = 32'd0;
`endif
    chk("m_count",    32'(count),    32'(sz));
    chk("m_st_ready", 32'(st_ready), 32'(sz != DEPTH));
    chk("m_dm_we",    32'(dm_we),    32'((sz != 0) && !dm_busy));
    chk("m_dm_addr",  dm_addr,       (sz != 0) ? mq[0].a : 32'd0);
    chk("m_dm_wdata", dm_wdata,      (sz != 0) ? mq[0].d : 32'd0);
    chk("m_dm_pc",    dm_pc,         (sz != 0) ? mq[0].p : 32'd0);
    chk("m_ld_hit",   32'(ld_hit),   32'(e_hit));
    chk("m_ld_data",  ld_data,       e_ld);
  end

  // Apply one cycle of inputs just after the rising edge, then settle.
  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la, input logic busy);
    @(posedge clk);
    #1;
    st_valid = sv;
    st_addr  = sa;
    st_data  = sd;
    st_pc    = sa + 32'h0000_1000;
    ld_valid = lv;
    ld_addr  = la;
    dm_busy  = busy;
    #2;
  endtask

  task automatic idle(input logic busy);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, busy);
  endtask

  localparam logic [31:0] FWD20 =
`ifdef STORE_BUF_FWD_EN
    32'd2;
`else
    32'd0;
`endif
  localparam logic [31:0] FWD30 =
`ifdef STORE_BUF_FWD_EN
    32'h33;
`else
    32'd0;
`endif

  initial begin
    n_vec    = 0;
    n_fail   = 0;
    reset    = 1'b1;
    st_valid = 1'b0;
    st_addr  = 32'd0;
    st_data  = 32'd0;
    st_pc    = 32'd0;
    ld_valid = 1'b0;
    ld_addr  = 32'd0;
    dm_busy  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #3;
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_dm_we",    32'(dm_we),    32'd0);
    chk("rst_ld_hit",   32'(ld_hit),   32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single store drains one cycle after its push
    drive(1'b1, 32'h10, 32'hAABBCCDD, 1'b0, 32'd0, 1'b0);
    chk("push_cycle_we", 32'(dm_we), 32'd0);
    idle(1'b0);
    chk("drain_we",    32'(dm_we), 32'd1);
    chk("drain_addr",  dm_addr,    32'h10);
    chk("drain_wdata", dm_wdata,   32'hAABBCCDD);
    chk("drain_pc",    dm_pc,      32'h1010);
    idle(1'b0);
    chk("drained_count", 32'(count), 32'd0);

    // Fill while memory is busy, fifth store ignored, then ordered drain
    for (int k = 0; k < 4; k++)
      drive(1'b1, 32'h100 + 32'(4 * k), 32'h1000 + 32'(k), 1'b0, 32'd0, 1'b1);
    drive(1'b1, 32'h200, 32'hDEAD, 1'b0, 32'd0, 1'b1);
    chk("full_count", 32'(count),    32'd4);
    chk("full_ready", 32'(st_ready), 32'd0);
    drive(1'b1, 32'h200, 32'hDEAD, 1'b0, 32'd0, 1'b1);
    chk("full_hold_count", 32'(count), 32'd4);
    idle(1'b0);
    chk("order0_addr", dm_addr,  32'h100);
    chk("order0_data", dm_wdata, 32'h1000);
    idle(1'b0);
    chk("order1_addr", dm_addr,  32'h104);
    idle(1'b0);
    chk("order2_addr", dm_addr,  32'h108);
    idle(1'b0);
    chk("order3_addr", dm_addr,  32'h10C);
    chk("order3_data", dm_wdata, 32'h1003);
    idle(1'b0);
    chk("order_empty", 32'(count), 32'd0);

    // Full push+pop rejects the push; at 3 push+pop keeps count
    for (int k = 0; k < 4; k++)
      drive(1'b1, 32'h300 + 32'(4 * k), 32'h3000 + 32'(k), 1'b0, 32'd0, 1'b1);
    drive(1'b1, 32'h400, 32'h4000, 1'b0, 32'd0, 1'b0);
    chk("fpp_ready", 32'(st_ready), 32'd0);
    chk("fpp_we",    32'(dm_we),    32'd1);
    drive(1'b1, 32'h404, 32'h4004, 1'b0, 32'd0, 1'b0);
    chk("fpp_count3", 32'(count), 32'd3);
    idle(1'b1);
    chk("pp3_count", 32'(count), 32'd3);
    chk("pp3_head",  dm_addr,    32'h308);
    for (int k = 0; k < 12; k++)
      drive((k % 3) != 2, 32'h500 + 32'(4 * k), 32'h5000 + 32'(k), 1'b0, 32'd0, (k % 2) == 1);
    repeat (6) idle(1'b0);
    chk("wrap_empty", 32'(count), 32'd0);

    // Two stores to one address, load forwards the younger
    drive(1'b1, 32'h20, 32'd1, 1'b0, 32'd0, 1'b1);
    drive(1'b1, 32'h20, 32'd2, 1'b0, 32'd0, 1'b1);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 32'h20, 1'b1);
    chk("fwd_hit",  32'(ld_hit), 32'd1);
    chk("fwd_data", ld_data,     FWD20);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 32'h24, 1'b1);
    chk("fwd_miss", 32'(ld_hit), 32'd0);
    repeat (3) idle(1'b0);

    // Same-cycle push does not match; next cycle it does, even while popping
    drive(1'b1, 32'h30, 32'h33, 1'b1, 32'h30, 1'b0);
    chk("samecyc_hit", 32'(ld_hit), 32'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 32'h30, 1'b0);
    chk("nextcyc_hit",  32'(ld_hit), 32'd1);
    chk("nextcyc_data", ld_data,     FWD30);
    chk("nextcyc_we",   32'(dm_we),  32'd1);
    idle(1'b0);

    // Asynchronous reset mid-cycle with three entries pending
    for (int k = 0; k < 3; k++)
      drive(1'b1, 32'h600 + 32'(4 * k), 32'h6000 + 32'(k), 1'b0, 32'd0, 1'b1);
    idle(1'b0);
    chk("pre_rst_we", 32'(dm_we), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_count", 32'(count),    32'd0);
    chk("arst_we",    32'(dm_we),    32'd0);
    chk("arst_ready", 32'(st_ready), 32'd1);
    chk("arst_addr",  dm_addr,       32'd0);
    @(posedge clk);
    #3;
    chk("arst_hold_we", 32'(dm_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idle(1'b0);
      chk("post_rst_we", 32'(dm_we), 32'd0);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
